mem_lane_bridge: RTL and testbench

Parametrised bridge between a narrow pin-level lane interface and a word-wide memory. The load path assembles LANE_W-bit lanes into WORD_W-bit words and writes them to consecutive addresses. The readback path fetches a block of words and streams them out lane by lane under a valid/ready handshake. It replaces fixed 8-of-32 byte muxing at the top level, generalising word width, lane width, address depth and lane order, and adds backpressure, block length and end-of-block marking.

---
 rtl/mem_lane_bridge.sv | 213 +++++++++++++++++++++
 tb/tb_mem_lane_bridge.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lane_bridge.sv
// Lane-to-word bridge between a narrow pin lane and a word-wide memory.
// Load path packs lanes into words; readback streams words out lane by lane.
module mem_lane_bridge #(
  parameter int WORD_W    = 32,
  parameter int LANE_W    = 8,
  parameter int ADDR_W    = 7,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  input  logic [LANE_W-1:0] ld_data,
  input  logic              ld_addr_set,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [ADDR_W:0]   rd_count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              out_valid,
  output logic [LANE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy
);

  // state  | meaning
  // IDLE   | no block in flight, waiting for rd_start with nonzero count
  // FETCH  | mem_re asserted for the current word address
  // WAIT   | read data returns; captured into the shift register
  // SHIFT  | lanes presented on out_data, one per handshake

  localparam int LANES = WORD_W / LANE_W;
  localparam int LCW   = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LCW-1:0]  LAST_IDX = LCW'(LANES - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_SHIFT} state_t;

  function automatic logic [LANE_W-1:0] get_lane(input logic [WORD_W-1:0] w,
                                                 input logic [LCW-1:0]    idx);
    logic [LANE_W-1:0] r;
    int                pos;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      pos = MSB_FIRST ? (LANES - 1 - i) : i;
      if (idx == LCW'(i)) r = w[pos*LANE_W +: LANE_W];
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] put_lane(input logic [WORD_W-1:0] w,
                                                 input logic [LCW-1:0]    idx,
                                                 input logic [LANE_W-1:0] lane);
    logic [WORD_W-1:0] r;
    int                pos;
    r = w;
    for (int i = 0; i < LANES; i++) begin
      pos = MSB_FIRST ? (LANES - 1 - i) : i;
      if (idx == LCW'(i)) r[pos*LANE_W +: LANE_W] = lane;
    end
    return r;
  endfunction

  // ---------------- load path ----------------
  logic [LCW-1:0]    lane_cnt_q, lane_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q, mem_waddr_d;
  logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

  always_comb begin
    lane_cnt_d  = lane_cnt_q;
    word_d      = word_q;
    waddr_d     = waddr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    // an address load wins over a coincident lane and drops any partial word
    if (ld_addr_set) begin
      waddr_d    = ld_addr;
      lane_cnt_d = '0;
      word_d     = '0;
    end else if (ld_valid) begin
      word_d = put_lane(word_q, lane_cnt_q, ld_data);
      if (lane_cnt_q == LAST_IDX) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = waddr_q;
        mem_wdata_d = word_d;
        waddr_d     = waddr_q + ADDR_W'(1);
        lane_cnt_d  = '0;
        word_d      = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + LCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q  <= '0;
      word_q      <= '0;
      waddr_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      lane_cnt_q  <= lane_cnt_d;
      word_q      <= word_d;
      waddr_q     <= waddr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ---------------- readback FSM ----------------
  state_t            state_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W:0]   remain_q;
  logic [LCW-1:0]    out_idx_q;
  logic [WORD_W-1:0] shreg_q;
  logic              mem_re_q;
  logic [ADDR_W-1:0] mem_raddr_q;
  logic              out_valid_q;
  logic [LANE_W-1:0] out_data_q;
  logic              out_last_q;
  logic              busy_q;
  logic [LCW-1:0]    out_idx_inc;
  logic [ADDR_W-1:0] rd_addr_inc;

  assign out_idx_inc = out_idx_q + LCW'(1);
  assign rd_addr_inc = rd_addr_q + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      remain_q    <= '0;
      out_idx_q   <= '0;
      shreg_q     <= '0;
      mem_re_q    <= 1'b0;
      mem_raddr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_re_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rd_start && (rd_count != '0)) begin
            rd_addr_q   <= rd_base;
            remain_q    <= rd_count;
            mem_re_q    <= 1'b1;
            mem_raddr_q <= rd_base;
            busy_q      <= 1'b1;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_WAIT;
        S_WAIT: begin
          shreg_q     <= mem_rdata;
          out_idx_q   <= '0;
          out_valid_q <= 1'b1;
          out_data_q  <= get_lane(mem_rdata, '0);
          out_last_q  <= 1'b0;
          state_q     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (out_ready) begin
            if (out_idx_q == LAST_IDX) begin
              remain_q    <= remain_q - CNT_ONE;
              rd_addr_q   <= rd_addr_inc;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              if (remain_q == CNT_ONE) begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end else begin
                mem_re_q    <= 1'b1;
                mem_raddr_q <= rd_addr_inc;
                state_q     <= S_FETCH;
              end
            end else begin
              out_idx_q  <= out_idx_inc;
              out_data_q <= get_lane(shreg_q, out_idx_inc);
              out_last_q <= (out_idx_inc == LAST_IDX) && (remain_q == CNT_ONE);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_raddr = mem_raddr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_lane_bridge.sv
// Directed bench for mem_lane_bridge: LSB-first instance with a memory model,
// plus an MSB-first instance exercised on its load path only.
module tb_mem_lane_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       a_ld_valid, a_ld_addr_set, a_mem_we, a_rd_start, a_mem_re;
  logic [7:0] a_ld_data, a_rd_count, a_out_data;
  logic [6:0] a_ld_addr, a_mem_waddr, a_rd_base, a_mem_raddr;
  logic [31:0] a_mem_wdata, a_mem_rdata;
  logic       a_out_valid, a_out_last, a_out_ready, a_busy;

  logic       b_ld_valid, b_ld_addr_set, b_mem_we, b_rd_start, b_mem_re;
  logic [7:0] b_ld_data, b_rd_count, b_out_data;
  logic [6:0] b_ld_addr, b_mem_waddr, b_rd_base, b_mem_raddr;
  logic [31:0] b_mem_wdata, b_mem_rdata;
  logic       b_out_valid, b_out_last, b_out_ready, b_busy;

  mem_lane_bridge #(.WORD_W(32), .LANE_W(8), .ADDR_W(7), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_addr_set(a_ld_addr_set), .ld_addr(a_ld_addr),
    .mem_we(a_mem_we), .mem_waddr(a_mem_waddr), .mem_wdata(a_mem_wdata),
    .rd_start(a_rd_start), .rd_base(a_rd_base), .rd_count(a_rd_count),
    .mem_re(a_mem_re), .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_ready(a_out_ready), .busy(a_busy));

  mem_lane_bridge #(.WORD_W(32), .LANE_W(8), .ADDR_W(7), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_addr_set(b_ld_addr_set), .ld_addr(b_ld_addr),
    .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_wdata(b_mem_wdata),
    .rd_start(b_rd_start), .rd_base(b_rd_base), .rd_count(b_rd_count),
    .mem_re(b_mem_re), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_ready(b_out_ready), .busy(b_busy));

  // memory model: write on mem_we, read data one cycle after mem_re
  logic [31:0] mem [128];
  always @(posedge clk) begin
    if (a_mem_we) mem[a_mem_waddr] <= a_mem_wdata;
    if (a_mem_re) a_mem_rdata <= mem[a_mem_raddr];
  end

  logic [8:0] rx_q[$];
  logic [6:0] ra_q[$];
  int         wr_cnt_b   = 0;
  int         stall_viol = 0;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_d    = '0;
  logic       stall_l    = 1'b0;

  always @(posedge clk) begin
    if (a_out_valid && a_out_ready) rx_q.push_back({a_out_last, a_out_data});
    if (a_mem_re) ra_q.push_back(a_mem_raddr);
    if (b_mem_we) wr_cnt_b <= wr_cnt_b + 1;
    if (stall_pend && (!a_out_valid || a_out_data !== stall_d || a_out_last !== stall_l))
      stall_viol <= stall_viol + 1;
    stall_pend <= a_out_valid && !a_out_ready;
    stall_d    <= a_out_data;
    stall_l    <= a_out_last;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ld_set(input bit sel, input logic [6:0] a);
    @(negedge clk);
    if (sel) begin b_ld_addr_set = 1'b1; b_ld_addr = a; end
    else     begin a_ld_addr_set = 1'b1; a_ld_addr = a; end
    @(negedge clk);
    a_ld_addr_set = 1'b0;
    b_ld_addr_set = 1'b0;
  endtask

  // lane i of w is w[8i+7:8i], driven on consecutive cycles
  task automatic ld_lanes(input bit sel, input int n, input logic [31:0] w);
    for (int i = 0; i < n; i++) begin
      if (sel) begin b_ld_valid = 1'b1; b_ld_data = w[8*i +: 8]; end
      else     begin a_ld_valid = 1'b1; a_ld_data = w[8*i +: 8]; end
      @(negedge clk);
    end
    a_ld_valid = 1'b0;
    b_ld_valid = 1'b0;
  endtask

  task automatic chk_stream(input string tag, input int base, input int n,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] w;
    logic [8:0]  obs;
    logic [8:0]  exp;
    chk({tag, "_count"}, rx_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      w   = (i < 4) ? w0 : ((i < 8) ? w1 : w2);
      exp = {(i == n - 1), w[8*(i%4) +: 8]};
      obs = (rx_q.size() > base + i) ? rx_q[base + i] : 9'h1xx;
      chk($sformatf("%s_lane%0d", tag, i), obs, exp);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!a_busy) break;
    end
  endtask

  int rb, ab, wc;
  bit done;

  initial begin
    rst_n = 1'b0;
    a_ld_valid = 0; a_ld_addr_set = 0; a_ld_data = 0; a_ld_addr = 0;
    a_rd_start = 0; a_rd_base = 0; a_rd_count = 0; a_out_ready = 1;
    b_ld_valid = 0; b_ld_addr_set = 0; b_ld_data = 0; b_ld_addr = 0;
    b_rd_start = 0; b_rd_base = 0; b_rd_count = 0; b_out_ready = 1; b_mem_rdata = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_we", a_mem_we, 0);
    chk("rst_mem_re", a_mem_re, 0);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_last", a_out_last, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_busy", b_busy, 0);

    // LSB-first load
    ld_set(0, 7'd5);
    ld_lanes(0, 4, 32'h44332211);
    chk("ld_we", a_mem_we, 1);
    chk("ld_waddr", a_mem_waddr, 5);
    chk("ld_wdata", a_mem_wdata, 32'h44332211);
    @(negedge clk);
    chk("ld_we_pulse", a_mem_we, 0);
    ld_lanes(0, 4, 32'h88776655);
    chk("ld2_we", a_mem_we, 1);
    chk("ld2_waddr", a_mem_waddr, 6);
    chk("ld2_wdata", a_mem_wdata, 32'h88776655);

    // MSB-first load, then a partial word discarded by an address load
    ld_set(1, 7'd5);
    ld_lanes(1, 4, 32'h44332211);
    chk("msb_we", b_mem_we, 1);
    chk("msb_waddr", b_mem_waddr, 5);
    chk("msb_wdata", b_mem_wdata, 32'h11223344);
    @(negedge clk);
    wc = wr_cnt_b;
    ld_lanes(1, 3, 32'h00998877);
    chk("msb_partial_we", b_mem_we, 0);
    ld_set(1, 7'd20);
    ld_lanes(1, 4, 32'hDDCCBBAA);
    chk("msb_nowrite", wr_cnt_b, wc);
    chk("msb2_we", b_mem_we, 1);
    chk("msb2_waddr", b_mem_waddr, 20);
    chk("msb2_wdata", b_mem_wdata, 32'hAABBCCDD);

    // fill 126, 127 and wrap to 0 through the load path
    ld_set(0, 7'd126);
    ld_lanes(0, 4, 32'hA1B2C3D4);
    chk("fill126", a_mem_waddr, 126);
    ld_lanes(0, 4, 32'h01020304);
    chk("fill127", a_mem_waddr, 127);
    ld_lanes(0, 4, 32'hDEADBEEF);
    chk("fill_wrap", a_mem_waddr, 0);
    @(negedge clk);

    // readback of 3 words with address wrap, cycle-exact
    rb = rx_q.size(); ab = ra_q.size();
    a_rd_base = 7'd126; a_rd_count = 8'd3; a_rd_start = 1; a_out_ready = 1;
    @(negedge clk);
    a_rd_start = 0;
    chk("rb_t1_re", a_mem_re, 1);
    chk("rb_t1_raddr", a_mem_raddr, 126);
    chk("rb_t1_valid", a_out_valid, 0);
    chk("rb_t1_busy", a_busy, 1);
    @(negedge clk);
    chk("rb_t2_re", a_mem_re, 0);
    chk("rb_t2_valid", a_out_valid, 0);
    @(negedge clk);
    chk("rb_t3_valid", a_out_valid, 1);
    chk("rb_t3_data", a_out_data, 8'hD4);
    repeat (15) @(negedge clk);
    chk("rb_end_data", a_out_data, 8'hDE);
    chk("rb_end_last", a_out_last, 1);
    chk("rb_end_busy", a_busy, 1);
    @(negedge clk);
    chk("rb_busy_drop", a_busy, 0);
    chk("rb_valid_drop", a_out_valid, 0);
    chk_stream("rb", rb, 12, 32'hA1B2C3D4, 32'h01020304, 32'hDEADBEEF);
    chk("rb_nreads", ra_q.size() - ab, 3);
    chk("rb_raddr2", (ra_q.size() > ab + 2) ? ra_q[ab + 2] : 7'h7x, 0);

    // backpressure with an ignored rd_start while busy
    rb = rx_q.size(); ab = ra_q.size();
    @(negedge clk);
    a_rd_base = 7'd5; a_rd_count = 8'd2; a_rd_start = 1; a_out_ready = 1'($urandom_range(0, 1));
    done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      a_rd_start = (c == 6);
      if (c == 6) begin a_rd_base = 7'd0; a_rd_count = 8'd1; end
      a_out_ready = 1'($urandom_range(0, 1));
      if (!a_busy) done = 1;
    end
    a_out_ready = 1;
    a_rd_start = 0;
    chk("bp_done", a_busy, 0);
    chk_stream("bp", rb, 8, 32'h44332211, 32'h88776655, 32'h0);
    chk("bp_nreads", ra_q.size() - ab, 2);
    chk("bp_stable", stall_viol, 0);

    // zero-length block
    @(negedge clk);
    a_rd_base = 7'd3; a_rd_count = 8'd0; a_rd_start = 1;
    @(negedge clk);
    a_rd_start = 0;
    chk("zero_busy", a_busy, 0);
    chk("zero_re", a_mem_re, 0);
    @(negedge clk);
    chk("zero_busy2", a_busy, 0);

    // load concurrent with readback
    rb = rx_q.size();
    @(negedge clk);
    a_rd_base = 7'd126; a_rd_count = 8'd3; a_rd_start = 1;
    a_ld_addr_set = 1; a_ld_addr = 7'd40;
    @(negedge clk);
    a_rd_start = 0; a_ld_addr_set = 0;
    ld_lanes(0, 4, 32'hCAFEF00D);
    chk("cc_we", a_mem_we, 1);
    chk("cc_waddr", a_mem_waddr, 40);
    chk("cc_wdata", a_mem_wdata, 32'hCAFEF00D);
    wait_idle(100);
    chk("cc_done", a_busy, 0);
    chk_stream("cc", rb, 12, 32'hA1B2C3D4, 32'h01020304, 32'hDEADBEEF);

    // asynchronous reset mid-block with a partial load word pending
    @(negedge clk);
    a_rd_base = 7'd5; a_rd_count = 8'd2; a_rd_start = 1;
    @(negedge clk);
    a_rd_start = 0;
    ld_lanes(0, 2, 32'h0000BBAA);
    @(negedge clk);
    chk("mid_valid", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", a_out_valid, 0);
    chk("arst_data", a_out_data, 0);
    chk("arst_last", a_out_last, 0);
    chk("arst_re", a_mem_re, 0);
    chk("arst_we", a_mem_we, 0);
    chk("arst_busy", a_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ld_lanes(0, 4, 32'h76543210);
    chk("post_waddr", a_mem_waddr, 0);
    chk("post_wdata", a_mem_wdata, 32'h76543210);
    rb = rx_q.size();
    @(negedge clk);
    a_rd_base = 7'd6; a_rd_count = 8'd1; a_rd_start = 1;
    @(negedge clk);
    a_rd_start = 0;
    wait_idle(100);
    chk("post_done", a_busy, 0);
    chk_stream("post", rb, 4, 32'h88776655, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
